// File: rtl/zrle_packer.sv
// zrle_packer: zero-run-length coding stage of the EBPC encoder.
// Classifies each accepted symbol as zero / non-zero and emits left-aligned
// variable-length codes ('1' for non-zero, '0' + (n-1) for a run of n zeros)
// into a one-entry output register feeding the shift streamer. At end of block
// it drives the streamer's flush/idle handshake.
// Optional build macro ZRLE_PACKER_STATS_EN adds saturating symbol counters
// (nz_cnt_o, zero_cnt_o).
module zrle_packer #(
    parameter int DATA_W       = 8,
    parameter int MAX_ZRLE_LEN = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          last_i,
    input  logic                          vld_i,
    output logic                          rdy_o,
    output logic [2*DATA_W-1:0]           data_o,
    output logic [$clog2(DATA_W+1)-1:0]   shift_o,
    output logic                          flush_o,
    output logic                          vld_o,
    input  logic                          rdy_i,
    input  logic                          idle_i,
    output logic                          idle_o
`ifdef ZRLE_PACKER_STATS_EN
    ,
    output logic [31:0]                   nz_cnt_o,
    output logic [31:0]                   zero_cnt_o
`endif
);

    localparam int RL_W  = $clog2(MAX_ZRLE_LEN);
    localparam int LEN_W = $clog2(DATA_W + 1);
    localparam int OUT_W = 2 * DATA_W;

    localparam logic [RL_W-1:0]  RUN_MAX_M1 = RL_W'(MAX_ZRLE_LEN - 1);
    localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_RUN    = LEN_W'(1 + RL_W);

    generate
        if (1 + RL_W > DATA_W) begin : g_bad_width
            $error("zrle_packer: 1+RL_W exceeds DATA_W");
        end
        if ((1 << RL_W) != MAX_ZRLE_LEN) begin : g_bad_max
            $error("zrle_packer: MAX_ZRLE_LEN must be a power of two");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_PEND_NZ    = 2'd1,
        ST_FLUSH_WAIT = 2'd2,
        ST_FLUSH      = 2'd3
    } state_e;

    // Run code: MSB 0, then (n-1) MSB first, remaining LSBs zero.
    function automatic logic [OUT_W-1:0] run_code(input logic [RL_W-1:0] n_m1);
        run_code = {1'b0, n_m1, {(OUT_W-1-RL_W){1'b0}}};
    endfunction

    // Non-zero marker code: a single '1' at the MSB.
    function automatic logic [OUT_W-1:0] one_code();
        one_code = {1'b1, {(OUT_W-1){1'b0}}};
    endfunction

    state_e            state_r, state_nxt_s;
    logic [RL_W-1:0]   run_cnt_r, run_cnt_nxt_s;
    logic              pend_last_r, pend_last_nxt_s;
    logic              live_r;
    logic              vld_r;
    logic [OUT_W-1:0]  data_r;
    logic [LEN_W-1:0]  shift_r;
    logic              free_s;
    logic              accept_s;
    logic              zero_s;
    logic              load_s;
    logic [OUT_W-1:0]  code_s;
    logic [LEN_W-1:0]  len_s;

    assign free_s   = !vld_r || rdy_i;
    assign zero_s   = (data_i == {DATA_W{1'b0}});
    assign accept_s = vld_i && rdy_o;

    // State, run counter and pending-last register; live_r keeps rdy_o low during/just after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_SCAN;
            run_cnt_r   <= {RL_W{1'b0}};
            pend_last_r <= 1'b0;
            live_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            run_cnt_r   <= run_cnt_nxt_s;
            pend_last_r <= pend_last_nxt_s;
            live_r      <= 1'b1;
        end
    end

    // Next-state, run bookkeeping and code selection.
    always_comb begin
        state_nxt_s     = state_r;
        run_cnt_nxt_s   = run_cnt_r;
        pend_last_nxt_s = pend_last_r;
        load_s          = 1'b0;
        code_s          = {OUT_W{1'b0}};
        len_s           = {LEN_W{1'b0}};
        case (state_r)
            ST_SCAN: begin
                if (accept_s) begin
                    if (zero_s) begin
                        if (last_i || (run_cnt_r == RUN_MAX_M1)) begin
                            // n-1 equals the current count in both cases.
                            load_s        = 1'b1;
                            code_s        = run_code(run_cnt_r);
                            len_s         = LEN_RUN;
                            run_cnt_nxt_s = {RL_W{1'b0}};
                            if (last_i) begin
                                state_nxt_s = ST_FLUSH_WAIT;
                            end else begin
                                state_nxt_s = ST_SCAN;
                            end
                        end else begin
                            run_cnt_nxt_s = run_cnt_r + RL_W'(1);
                        end
                    end else if (run_cnt_r == {RL_W{1'b0}}) begin
                        load_s = 1'b1;
                        code_s = one_code();
                        len_s  = LEN_ONE;
                        if (last_i) begin
                            state_nxt_s = ST_FLUSH_WAIT;
                        end else begin
                            state_nxt_s = ST_SCAN;
                        end
                    end else begin
                        // Close the open run first; the '1' follows from PEND_NZ.
                        load_s          = 1'b1;
                        code_s          = run_code(run_cnt_r - RL_W'(1));
                        len_s           = LEN_RUN;
                        run_cnt_nxt_s   = {RL_W{1'b0}};
                        pend_last_nxt_s = last_i;
                        state_nxt_s     = ST_PEND_NZ;
                    end
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_PEND_NZ: begin
                if (free_s) begin
                    load_s = 1'b1;
                    code_s = one_code();
                    len_s  = LEN_ONE;
                    if (pend_last_r) begin
                        state_nxt_s = ST_FLUSH_WAIT;
                    end else begin
                        state_nxt_s = ST_SCAN;
                    end
                end else begin
                    state_nxt_s = ST_PEND_NZ;
                end
            end
            ST_FLUSH_WAIT: begin
                if (!vld_r) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_FLUSH_WAIT;
                end
            end
            ST_FLUSH: begin
                if (idle_i) begin
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: begin
                state_nxt_s = ST_SCAN;
            end
        endcase
    end

    // One-entry output register: loads a new code when free, otherwise holds until taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_r   <= 1'b0;
            data_r  <= {OUT_W{1'b0}};
            shift_r <= {LEN_W{1'b0}};
        end else if (load_s) begin
            vld_r   <= 1'b1;
            data_r  <= code_s;
            shift_r <= len_s;
        end else if (rdy_i) begin
            vld_r   <= 1'b0;
        end
    end

    // Handshake and status outputs decoded from registered state.
    always_comb begin
        rdy_o   = 1'b0;
        flush_o = 1'b0;
        idle_o  = 1'b0;
        case (state_r)
            ST_SCAN: begin
                rdy_o  = live_r && free_s;
                idle_o = (run_cnt_r == {RL_W{1'b0}}) && !vld_r;
            end
            ST_FLUSH: begin
                flush_o = 1'b1;
            end
            default: begin
                rdy_o = 1'b0;
            end
        endcase
    end

    assign vld_o   = vld_r;
    assign data_o  = data_r;
    assign shift_o = shift_r;

`ifdef ZRLE_PACKER_STATS_EN
    // Saturating symbol counters, cleared when the flush handshake completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nz_cnt_o   <= 32'd0;
            zero_cnt_o <= 32'd0;
        end else if ((state_r == ST_FLUSH) && idle_i) begin
            nz_cnt_o   <= 32'd0;
            zero_cnt_o <= 32'd0;
        end else if (accept_s) begin
            if (!zero_s && (nz_cnt_o != 32'hFFFF_FFFF)) begin
                nz_cnt_o <= nz_cnt_o + 32'd1;
            end else if (zero_s && (zero_cnt_o != 32'hFFFF_FFFF)) begin
                zero_cnt_o <= zero_cnt_o + 32'd1;
            end else begin
                nz_cnt_o <= nz_cnt_o;
            end
        end else begin
            nz_cnt_o <= nz_cnt_o;
        end
    end
`endif

endmodule

// File: doc/zrle_packer.md
Name: zrle_packer

Overview:
- Zero-run-length coding stage of the EBPC encoder. Sits directly upstream of the shift streamer.
- Consumes one DATA_W-bit activation per handshake and classifies it as zero or non-zero.
- Emits left-aligned variable-length codes (2*DATA_W bus plus code length) that the shift streamer packs into DATA_W-bit words.
- At end of block, drives the streamer's flush/idle protocol.

Parameters:
- DATA_W, 8, input symbol width; also sets output bus width 2*DATA_W.
- MAX_ZRLE_LEN, 16, longest zero run coded by one symbol; power of two.
- RL_W = $clog2(MAX_ZRLE_LEN) is derived, not overridable. Elaboration error if 1+RL_W > DATA_W.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- data_i  in  DATA_W  input symbol
- last_i  in  1  final symbol of block
- vld_i  in  1  input valid
- rdy_o  out  1  input ready
- data_o  out  2*DATA_W  code, MSB-aligned, unused LSBs zero
- shift_o  out  $clog2(DATA_W+1)  code length in bits (1 or 1+RL_W)
- flush_o  out  1  flush request to streamer
- vld_o  out  1  code valid
- rdy_i  in  1  streamer ready
- idle_i  in  1  streamer idle
- idle_o  out  1  packer idle (SCAN state, run_cnt 0, output register empty)

Behaviour:
- Output is a one-entry register (code, len, vld). Reset: vld_o=0, data_o=0, shift_o=0, flush_o=0, rdy_o=0, run_cnt=0, state SCAN.
- idle_o reset value: 1 (reset state satisfies the idle conditions).
- Register free = !vld_q || rdy_i. Register loads only when free.
- Codes:
  - non-zero: bit[2*DATA_W-1]=1, shift_o=1.
  - zero run of length n (1..MAX_ZRLE_LEN): MSB=0, next RL_W bits = n-1 (MSB first), shift_o=1+RL_W.
- States: SCAN, PEND_NZ, FLUSH_WAIT, FLUSH.
- SCAN: rdy_o = free. On accepted input:
  - zero, !last, run_cnt+1 < MAX: run_cnt++, no code emitted.
  - zero, !last, run_cnt+1 == MAX: load run code (n=MAX), run_cnt=0.
  - zero, last: load run code (n=run_cnt+1), run_cnt=0, go to FLUSH_WAIT.
  - non-zero, run_cnt==0: load '1' code. If last, go to FLUSH_WAIT.
  - non-zero, run_cnt>0: load run code (n=run_cnt), run_cnt=0, latch pend_last=last, go to PEND_NZ.
- PEND_NZ: rdy_o=0. When free: load '1' code, then go to FLUSH_WAIT if pend_last, else SCAN.
- FLUSH_WAIT: rdy_o=0. When !vld_q (last code accepted), go to FLUSH.
- FLUSH: flush_o=1, vld_o=0, rdy_o=0. Hold flush_o until idle_i is sampled 1, then return to SCAN next cycle.
- Latency: a code appears on vld_o one cycle after the input that completes it. Throughput is one symbol per cycle, except one bubble for each run followed by a non-zero.
- vld_o/data_o/shift_o stay stable while vld_o && !rdy_i.
- Run counter never exceeds MAX_ZRLE_LEN-1 between codes; no wrap-around.
- Reset mid-operation discards the partial run and any pending code.

Optional Feature:
- Macro: ZRLE_PACKER_STATS_EN.
- Defined: adds output ports nz_cnt_o and zero_cnt_o, 32 bits each.
  - nz_cnt_o counts accepted non-zero symbols; zero_cnt_o counts accepted zero symbols.
  - Both clear on reset and when FLUSH exits; both saturate at all-ones.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- DATA_W=8, MAX=16; send 5,0,0,0,7(last), rdy_i=1 -> codes {1,len1}, {0+0010,len5}, {1,len1}; rdy_o low one cycle before 7's '1' code; flush_o high until idle_i=1.
- 20 zeros, last on the 20th -> run code n=16 (bits 0_1111), then n=4 (0_0011, last), then flush.
- Single non-zero with last -> one '1' code; FLUSH_WAIT->FLUSH; flush_o held 3 cycles while idle_i=0, drops the cycle after idle_i=1.
- Backpressure: rdy_i=0 for 4 cycles mid-stream -> data_o/shift_o stable, rdy_o=0, no lost or duplicated codes.
- Reset asserted while in PEND_NZ -> all outputs reset-valued immediately; next symbol 3 -> single '1' code.
- Random 1000 symbols (50% zero) into the shift streamer model -> decoded stream matches input; with ZRLE_PACKER_STATS_EN, counters match reference counts.
